// File: rtl/imm_arbiter.sv
// imm_arbiter: two-port round-robin front end for a single RV32I immediate
// generator. A (decode) and B (branch lookahead) share one ImmGen; the
// granted request's immediate comes back through a one-entry registered
// response channel with a valid/ready handshake, source ID and tag.

// Combinational RV32I immediate extraction (I/S/B/U/J, sign-extended).
module imm_gen (
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  fmt_e        w_fmt;
  logic [6:0]  w_opcode;
  logic        w_sign;

  assign w_opcode = i_instr[6:0];
  assign w_sign   = i_instr[31];

  // Classify the opcode into an immediate format; anything else has no immediate.
  always_comb begin
    w_fmt = FMT_NONE;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR: w_fmt = FMT_I;
      OP_STORE:                 w_fmt = FMT_S;
      OP_BRANCH:                w_fmt = FMT_B;
      OP_LUI, OP_AUIPC:         w_fmt = FMT_U;
      OP_JAL:                   w_fmt = FMT_J;
      default:                  w_fmt = FMT_NONE;
    endcase
  end

  // Assemble the scattered immediate bits for the selected format.
  always_comb begin
    o_imm = 32'h0;
    case (w_fmt)
      FMT_I: o_imm = {{20{w_sign}}, i_instr[31:20]};
      FMT_S: o_imm = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: o_imm = {{19{w_sign}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U: o_imm = {i_instr[31:12], 12'h000};
      FMT_J: o_imm = {{11{w_sign}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = 32'h0;
    endcase
  end

endmodule

// Round-robin arbiter with one-entry registered response.
module imm_arbiter #(
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned RR_INIT = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [31:0]      i_a_instr,
  input  logic [TAG_W-1:0] i_a_tag,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  input  logic [31:0]      i_b_instr,
  input  logic [TAG_W-1:0] i_b_tag,
  input  logic             i_flush,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_src,
  output logic [31:0]      o_rsp_imm,
  output logic [TAG_W-1:0] o_rsp_tag
);

  localparam logic PRIO_INIT = (RR_INIT != 0);

  // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
  logic             r_prio;
  logic             r_rsp_valid;
  logic             r_rsp_src;
  logic [31:0]      r_rsp_imm;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_can_accept;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_accept;
  logic [31:0]      w_sel_instr;
  logic [TAG_W-1:0] w_sel_tag;
  logic [31:0]      w_imm;

  // Readies are held low during reset so nothing is handshaken while the
  // response register is being cleared.
  assign w_can_accept = i_rstn && !i_flush && (!r_rsp_valid || i_rsp_ready);

  // Grant depends only on valids and the pointer, never on readies.
  assign w_grant_a = i_a_valid && (!i_b_valid || !r_prio);
  assign w_grant_b = i_b_valid && (!i_a_valid ||  r_prio);

  assign o_a_ready = w_grant_a && w_can_accept;
  assign o_b_ready = w_grant_b && w_can_accept;
  assign w_accept  = o_a_ready || o_b_ready;

  assign w_sel_instr = w_grant_b ? i_b_instr : i_a_instr;
  assign w_sel_tag   = w_grant_b ? i_b_tag   : i_a_tag;

  imm_gen u_imm_gen (
    .i_instr (w_sel_instr),
    .o_imm   (w_imm)
  );

  // Response register and pointer: flush beats accept, accept beats consume.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_prio      <= PRIO_INIT;
      r_rsp_valid <= 1'b0;
      r_rsp_src   <= 1'b0;
      r_rsp_imm   <= 32'h0;
      r_rsp_tag   <= '0;
    end else if (i_flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_src   <= w_grant_b;
      r_rsp_imm   <= w_imm;
      r_rsp_tag   <= w_sel_tag;
      r_prio      <= !w_grant_b;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_src   = r_rsp_src;
  assign o_rsp_imm   = r_rsp_imm;
  assign o_rsp_tag   = r_rsp_tag;

endmodule
